// File: rtl/clock_period_monitor.sv
// Measures the period of a slow clock-like input in clk cycles, with lock and loss flags.
// Optional high-time measurement enabled by defining CLK_MON_HIGH_EN.
`timescale 1ns/1ps
module clock_period_monitor #(
    parameter int Width      = 16,
    parameter int SyncStages = 2,
    parameter int Timeout    = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [Width-1:0] period,
    output logic             period_valid,
    output logic             locked,
`ifdef CLK_MON_HIGH_EN
    output logic [Width-1:0] high_time,
`endif
    output logic             lost
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] MEAS = 2'd2;

    localparam logic [Width-1:0] CntMax     = '1;
    localparam logic [Width-1:0] TimeoutVal = Width'(Timeout);
    localparam logic [Width-1:0] CntOne     = Width'(1);

    logic [1:0]            state;
    logic [SyncStages-1:0] sync_q;
    logic                  s;
    logic                  s_d;
    logic                  rise;
    logic [Width-1:0]      cnt;
    logic [Width-1:0]      cnt_inc;
    logic                  timed_out;
    logic                  have_prev;

    assign s         = sync_q[SyncStages-1];
    assign rise      = s & ~s_d;
    assign cnt_inc   = (cnt == CntMax) ? cnt : cnt + CntOne;
    assign timed_out = (cnt >= TimeoutVal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], sig_in};
            s_d    <= s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
            have_prev    <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!enable) begin
                state     <= IDLE;
                cnt       <= '0;
                locked    <= 1'b0;
                lost      <= 1'b0;
                have_prev <= 1'b0;
            end else begin
                unique case (1'b1)
                    (state == IDLE): begin
                        state <= ARM;
                        cnt   <= '0;
                    end
                    (state == ARM): begin
                        if (rise) begin
                            state     <= MEAS;
                            cnt       <= CntOne;
                            lost      <= 1'b0;
                            have_prev <= 1'b0;
                        end else if (timed_out) begin
                            lost   <= 1'b1;
                            locked <= 1'b0;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    (state == MEAS): begin
                        // A rise wins over a timeout landing on the same cycle.
                        if (rise) begin
                            period       <= cnt;
                            period_valid <= 1'b1;
                            locked       <= have_prev && (cnt == period);
                            have_prev    <= 1'b1;
                            cnt          <= CntOne;
                        end else if (timed_out) begin
                            state     <= ARM;
                            lost      <= 1'b1;
                            locked    <= 1'b0;
                            have_prev <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef CLK_MON_HIGH_EN
    logic [Width-1:0] hcnt;

    // The rise cycle itself has s=1, so a fresh period starts at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt      <= '0;
            high_time <= '0;
        end else if (!enable || state == IDLE) begin
            hcnt <= '0;
        end else if (rise) begin
            if (state == MEAS)
                high_time <= hcnt;
            hcnt <= CntOne;
        end else if (s && hcnt != CntMax) begin
            hcnt <= hcnt + CntOne;
        end
    end
`endif

endmodule

// File: tb/tb_clock_period_monitor.sv
// Directed bench for clock_period_monitor with Timeout=64.
`timescale 1ns/1ps
module tb_clock_period_monitor;

    localparam int W = 16;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b1;
    logic         enable = 1'b0;
    logic         sig_in = 1'b0;
    logic [W-1:0] period;
    logic         period_valid;
    logic         locked;
    logic         lost;
`ifdef CLK_MON_HIGH_EN
    logic [W-1:0] high_time;
`endif

    int checks   = 0;
    int errors   = 0;
    int half     = 0;
    int tcnt     = 0;
    int since_pv = 0;
    int last_gap = 0;
    int n_pv     = 0;
    int wp_ticks = 0;
    int n0       = 0;
    bit any_lost = 1'b0;

    clock_period_monitor #(
        .Width(W),
        .SyncStages(2),
        .Timeout(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .sig_in(sig_in),
        .period(period),
        .period_valid(period_valid),
        .locked(locked),
`ifdef CLK_MON_HIGH_EN
        .high_time(high_time),
`endif
        .lost(lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (period_valid) begin
            n_pv++;
            last_gap = since_pv + 1;
            since_pv = 0;
        end else begin
            since_pv++;
        end
        if (lost) any_lost = 1'b1;
        if (half > 0) begin
            tcnt++;
            if (tcnt >= half) begin
                sig_in = ~sig_in;
                tcnt = 0;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_pulse(input string tag, input int budget);
        wp_ticks = 0;
        do begin
            tick();
            wp_ticks++;
        end while (!period_valid && wp_ticks < budget);
        chk({tag, "_seen"}, int'(period_valid), 1);
    endtask

    task automatic wait_pulse_ne(input string tag, input int p, input int budget);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!(period_valid && int'(period) != p) && k < budget);
        chk({tag, "_seen"}, int'(period_valid && int'(period) != p), 1);
    endtask

    task automatic wait_level(input string tag, input logic lvl);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!(sig_in == lvl && tcnt == 0) && k < 100);
        chk({tag, "_edge"}, int'(sig_in == lvl && tcnt == 0), 1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #11;
        chk("rst_period", int'(period), 0);
        chk("rst_pv", int'(period_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_lost", int'(lost), 0);

        @(negedge clk) rst_n = 1'b1;
        half = 4;
        ticks(30);
        chk("idle_no_pv", n_pv, 0);
        chk("idle_lost", int'(lost), 0);

        // steady, period 8
        enable = 1'b1;
        wait_pulse("p1", 40);
        chk("p1_period", int'(period), 8);
        chk("p1_locked", int'(locked), 0);
        wait_pulse("p2", 20);
        chk("p2_period", int'(period), 8);
        chk("p2_locked", int'(locked), 1);
        chk("p2_gap", last_gap, 8);
`ifdef CLK_MON_HIGH_EN
        chk("p2_high", int'(high_time), 4);
`endif
        wait_pulse("p3", 20);
        chk("p3_locked", int'(locked), 1);
        chk("p3_lost", int'(lost), 0);

        // rate change to period 12
        wait_level("r12", 1'b1);
        half = 6;
        wait_pulse_ne("r1", 8, 40);
        chk("r1_period", int'(period), 12);
        chk("r1_locked", int'(locked), 0);
        wait_pulse("r2", 30);
        chk("r2_period", int'(period), 12);
        chk("r2_locked", int'(locked), 1);

        // back to period 8
        wait_level("r8", 1'b1);
        half = 4;
        wait_pulse_ne("b1", 12, 40);
        chk("b1_period", int'(period), 8);
        chk("b1_locked", int'(locked), 0);
        wait_pulse("b2", 20);
        chk("b2_locked", int'(locked), 1);

        // loss of input, held low
        wait_level("stop", 1'b0);
        half = 0;
        n0 = n_pv;
        begin
            int k = 0;
            do begin
                tick();
                k++;
            end while (!lost && k < 200);
        end
        chk("loss_seen", int'(lost), 1);
        chk("loss_gap", since_pv, 64);
        chk("loss_locked", int'(locked), 0);
        chk("loss_period", int'(period), 8);
        ticks(100);
        chk("loss_hold", int'(lost), 1);
        chk("loss_no_pv", n_pv - n0, 0);

        // restart after loss
        tcnt = 0;
        half = 4;
        begin
            int k = 0;
            do begin
                tick();
                k++;
            end while (lost && k < 50);
        end
        chk("rec_lost", int'(lost), 0);
        chk("rec_no_pv", n_pv - n0, 0);
        wait_pulse("rec1", 20);
        chk("rec1_period", int'(period), 8);
        chk("rec1_locked", int'(locked), 0);

        // enable drop two cycles before the expected rise
        wait_pulse("en0", 20);
        chk("en0_locked", int'(locked), 1);
        ticks(5);
        enable = 1'b0;
        tick();
        chk("en_drop_pv", int'(period_valid), 0);
        chk("en_drop_locked", int'(locked), 0);
        chk("en_drop_lost", int'(lost), 0);
        chk("en_drop_period", int'(period), 8);
        n0 = n_pv;
        ticks(20);
        chk("en_off_no_pv", n_pv - n0, 0);
        enable = 1'b1;
        wait_pulse("en1", 40);
        chk("en1_two_rises", int'(wp_ticks >= 9), 1);
        chk("en1_period", int'(period), 8);
        chk("en1_locked", int'(locked), 0);

        // period exactly equal to Timeout
        wait_level("t64", 1'b1);
        half = 32;
        any_lost = 1'b0;
        wait_pulse_ne("s1", 8, 200);
        chk("s1_period", int'(period), 64);
        chk("s1_lost", int'(lost), 0);
        wait_pulse("s2", 100);
        chk("s2_period", int'(period), 64);
        chk("s2_locked", int'(locked), 1);
        chk("s_never_lost", int'(any_lost), 0);
`ifdef CLK_MON_HIGH_EN
        chk("s2_high", int'(high_time), 32);
`endif

        // async reset mid-measurement
        ticks(10);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_period", int'(period), 0);
        chk("arst_pv", int'(period_valid), 0);
        chk("arst_locked", int'(locked), 0);
        chk("arst_lost", int'(lost), 0);
        enable = 1'b0;
        #10 rst_n = 1'b1;
        half = 4;
        n0 = n_pv;
        ticks(30);
        chk("post_rst_no_pv", n_pv - n0, 0);
        chk("post_rst_period", int'(period), 0);
        chk("post_rst_lost", int'(lost), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
